// File: rtl/l2_cache_write.sv
// L2 data write stage: merges store bytes into the read (or fill) line, drives
// the single SRAM write port, and registers the result for the response stage.
// A one-entry bypass covers the SRAM's one-cycle read-after-write window.

`ifndef CACHE_LINE_BITS
`define CACHE_LINE_BITS 512
`endif
`ifndef L2_SET_INDEX_WIDTH
`define L2_SET_INDEX_WIDTH 6
`endif
`ifndef L2_CACHE_ADDR_WIDTH
`define L2_CACHE_ADDR_WIDTH (`L2_SET_INDEX_WIDTH + 2)
`endif
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_cache_pkg;
  localparam int LINE_W  = `CACHE_LINE_BITS;
  localparam int SET_W   = `L2_SET_INDEX_WIDTH;
  localparam int IDX_W   = `L2_CACHE_ADDR_WIDTH;
  localparam int CORES   = `NUM_CORES;
  localparam int NUM_LANES = LINE_W / 8;
  localparam int VEC_W   = 8;

  typedef enum logic [2:0] {
    L2REQ_LOAD       = 3'd0,
    L2REQ_STORE      = 3'd1,
    L2REQ_FLUSH      = 3'd2,
    L2REQ_INVALIDATE = 3'd3,
    L2REQ_LOAD_SYNC  = 3'd4,
    L2REQ_STORE_SYNC = 3'd5
  } l2req_op_t;

  typedef struct packed {
    logic                 valid;
    l2req_op_t            op;
    logic [1:0]           core;
    logic [1:0]           strand;
    logic [25:0]          address;
    logic [LINE_W-1:0]    data;
    logic [NUM_LANES-1:0] mask;
  } l2req_packet_t;
endpackage

// One byte lane of the store merge.
module l2_byte_merge #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] new_b,
  input  logic [VEC_W-1:0] old_b,
  output logic [VEC_W-1:0] out_b
);
  // Select store byte when its mask bit is set.
  assign out_b = sel ? new_b : old_b;
endmodule

module l2_cache_write
  import l2_cache_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  l2req_packet_t           rd_l2req_packet,
  input  logic                    rd_is_l2_fill,
  input  logic [LINE_W-1:0]       rd_data_from_memory,
  input  logic [1:0]              rd_hit_l2_way,
  input  logic [1:0]              rd_miss_fill_l2_way,
  input  logic                    rd_cache_hit,
  input  logic [LINE_W-1:0]       rd_cache_mem_result,
  input  logic                    rd_store_sync_success,
  input  logic [CORES-1:0]        rd_l1_has_line,
  input  logic [CORES*2-1:0]      rd_dir_l1_way,
  output logic                    wr_update_enable,
  output logic [IDX_W-1:0]        wr_cache_write_index,
  output logic [LINE_W-1:0]       wr_update_data,
  output l2req_packet_t           wr_l2req_packet,
  output logic [LINE_W-1:0]       wr_data,
  output logic                    wr_cache_hit,
  output logic                    wr_is_l2_fill,
  output logic                    wr_store_sync_success,
  output logic [CORES-1:0]        wr_l1_has_line,
  output logic [CORES*2-1:0]      wr_dir_l1_way
);

  logic                 bypass_valid;
  logic [IDX_W-1:0]     bypass_index;
  logic [LINE_W-1:0]    bypass_data;

  logic [1:0]           way;
  logic [IDX_W-1:0]     index;
  logic                 bypass_hit;
  logic                 is_store;
  logic [NUM_LANES-1:0][VEC_W-1:0] old_line;
  logic [NUM_LANES-1:0][VEC_W-1:0] st_line;
  logic [NUM_LANES-1:0][VEC_W-1:0] merged;
  logic [LINE_W-1:0]    line_out;

  assign way   = rd_is_l2_fill ? rd_miss_fill_l2_way : rd_hit_l2_way;
  assign index = {way, rd_l2req_packet.address[SET_W-1:0]};
  assign bypass_hit = bypass_valid && (bypass_index == index);

  // Bypass wins over both memory fill data and the (possibly stale) SRAM read.
  assign old_line = bypass_hit    ? bypass_data :
                    rd_is_l2_fill ? rd_data_from_memory : rd_cache_mem_result;
  assign st_line  = rd_l2req_packet.data;

  assign is_store = (rd_l2req_packet.op == L2REQ_STORE) ||
                    ((rd_l2req_packet.op == L2REQ_STORE_SYNC) && rd_store_sync_success);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    l2_byte_merge #(.VEC_W(VEC_W)) u_merge (
      .sel   (rd_l2req_packet.mask[i]),
      .new_b (st_line[i]),
      .old_b (old_line[i]),
      .out_b (merged[i])
    );
  end

  // Non-stores (and failed sync stores) pass the base line through untouched.
  assign line_out = is_store ? merged : old_line;

  // Fills always write; hits write only for committed stores.
  assign wr_update_enable     = rd_l2req_packet.valid &&
                                (rd_is_l2_fill || (rd_cache_hit && is_store));
  assign wr_cache_write_index = index;
  assign wr_update_data       = line_out;

  // Remember the last write for one cycle to cover the SRAM RAW window.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bypass_valid <= 1'b0;
      bypass_index <= '0;
      bypass_data  <= '0;
    end else begin
      bypass_valid <= wr_update_enable;
      bypass_index <= wr_cache_write_index;
      bypass_data  <= wr_update_data;
    end
  end

  // Register request and post-update line for the response stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_l2req_packet       <= '0;
      wr_data               <= '0;
      wr_cache_hit          <= 1'b0;
      wr_is_l2_fill         <= 1'b0;
      wr_store_sync_success <= 1'b0;
      wr_l1_has_line        <= '0;
      wr_dir_l1_way         <= '0;
    end else begin
      wr_l2req_packet       <= rd_l2req_packet;
      wr_data               <= wr_update_enable ? line_out : old_line;
      wr_cache_hit          <= rd_cache_hit;
      wr_is_l2_fill         <= rd_is_l2_fill;
      wr_store_sync_success <= rd_store_sync_success;
      wr_l1_has_line        <= rd_l1_has_line;
      wr_dir_l1_way         <= rd_dir_l1_way;
    end
  end

endmodule

// File: tb/tb_l2_cache_write.sv
// Directed bench for l2_cache_write.
module tb_l2_cache_write;
  import l2_cache_pkg::*;

  logic                 clk;
  logic                 reset;
  l2req_packet_t        rd_l2req_packet;
  logic                 rd_is_l2_fill;
  logic [LINE_W-1:0]    rd_data_from_memory;
  logic [1:0]           rd_hit_l2_way;
  logic [1:0]           rd_miss_fill_l2_way;
  logic                 rd_cache_hit;
  logic [LINE_W-1:0]    rd_cache_mem_result;
  logic                 rd_store_sync_success;
  logic [CORES-1:0]     rd_l1_has_line;
  logic [CORES*2-1:0]   rd_dir_l1_way;
  logic                 wr_update_enable;
  logic [IDX_W-1:0]     wr_cache_write_index;
  logic [LINE_W-1:0]    wr_update_data;
  l2req_packet_t        wr_l2req_packet;
  logic [LINE_W-1:0]    wr_data;
  logic                 wr_cache_hit;
  logic                 wr_is_l2_fill;
  logic                 wr_store_sync_success;
  logic [CORES-1:0]     wr_l1_has_line;
  logic [CORES*2-1:0]   wr_dir_l1_way;

  int total = 0;
  int bad   = 0;

  l2_cache_write dut (
    .clk                   (clk),
    .reset                 (reset),
    .rd_l2req_packet       (rd_l2req_packet),
    .rd_is_l2_fill         (rd_is_l2_fill),
    .rd_data_from_memory   (rd_data_from_memory),
    .rd_hit_l2_way         (rd_hit_l2_way),
    .rd_miss_fill_l2_way   (rd_miss_fill_l2_way),
    .rd_cache_hit          (rd_cache_hit),
    .rd_cache_mem_result   (rd_cache_mem_result),
    .rd_store_sync_success (rd_store_sync_success),
    .rd_l1_has_line        (rd_l1_has_line),
    .rd_dir_l1_way         (rd_dir_l1_way),
    .wr_update_enable      (wr_update_enable),
    .wr_cache_write_index  (wr_cache_write_index),
    .wr_update_data        (wr_update_data),
    .wr_l2req_packet       (wr_l2req_packet),
    .wr_data               (wr_data),
    .wr_cache_hit          (wr_cache_hit),
    .wr_is_l2_fill         (wr_is_l2_fill),
    .wr_store_sync_success (wr_store_sync_success),
    .wr_l1_has_line        (wr_l1_has_line),
    .wr_dir_l1_way         (wr_dir_l1_way)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge; return 1ns after it so sampling is away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input l2req_op_t op, input logic [25:0] addr,
                         input logic [LINE_W-1:0] data, input logic [63:0] mask,
                         input logic fill, input logic [1:0] hway, input logic [1:0] mway,
                         input logic hit, input logic [LINE_W-1:0] mem_res,
                         input logic [LINE_W-1:0] fill_data, input logic sync_ok);
    rd_l2req_packet.valid   = 1'b1;
    rd_l2req_packet.op      = op;
    rd_l2req_packet.core    = 2'd1;
    rd_l2req_packet.strand  = 2'd2;
    rd_l2req_packet.address = addr;
    rd_l2req_packet.data    = data;
    rd_l2req_packet.mask    = mask;
    rd_is_l2_fill           = fill;
    rd_hit_l2_way           = hway;
    rd_miss_fill_l2_way     = mway;
    rd_cache_hit            = hit;
    rd_cache_mem_result     = mem_res;
    rd_data_from_memory     = fill_data;
    rd_store_sync_success   = sync_ok;
    #1;
  endtask

  task automatic set_idle();
    rd_l2req_packet       = '0;
    rd_is_l2_fill         = 1'b0;
    rd_cache_hit          = 1'b0;
    rd_store_sync_success = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_idle();
    rd_data_from_memory = '0;
    rd_cache_mem_result = '0;
    rd_hit_l2_way = '0;
    rd_miss_fill_l2_way = '0;
    rd_l1_has_line = 4'b1010;
    rd_dir_l1_way = 8'hC5;
    #20;
    total++;
    if (wr_data !== '0 || wr_l2req_packet !== '0 || wr_l1_has_line !== '0 ||
        wr_dir_l1_way !== '0 || wr_cache_hit !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: wr_data=%0h pkt_valid=%b l1=%b dir=%h", wr_data,
               wr_l2req_packet.valid, wr_l1_has_line, wr_dir_l1_way);
    end
    total++;
    if (wr_update_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_wen: got %b want 0", wr_update_enable);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_store_hit();
    set_req(L2REQ_STORE, 26'h0005, 512'hAB, 64'h1, 1'b0, 2'd2, 2'd0, 1'b1,
            '0, '0, 1'b0);
    total++;
    if (wr_update_enable !== 1'b1 || wr_cache_write_index !== 8'h85 ||
        wr_update_data !== 512'hAB) begin
      bad++;
      $display("FAIL store_hit_write: en=%b idx=%h data=%h want en=1 idx=85 data=ab",
               wr_update_enable, wr_cache_write_index, wr_update_data);
    end
    step();
    total++;
    if (wr_data !== 512'hAB || wr_cache_hit !== 1'b1 ||
        wr_l2req_packet.address !== 26'h0005 || wr_l1_has_line !== 4'b1010 ||
        wr_dir_l1_way !== 8'hC5) begin
      bad++;
      $display("FAIL store_hit_reg: wr_data=%h hit=%b addr=%h want ab/1/5",
               wr_data, wr_cache_hit, wr_l2req_packet.address);
    end
    set_idle();
    step();
  endtask

  task automatic test_back_to_back();
    set_req(L2REQ_STORE, 26'h0005, 512'h11, 64'h1, 1'b0, 2'd2, 2'd0, 1'b1,
            '0, '0, 1'b0);
    total++;
    if (wr_update_data !== 512'h11 || wr_update_enable !== 1'b1) begin
      bad++;
      $display("FAIL b2b_first: data=%h en=%b want 11/1", wr_update_data, wr_update_enable);
    end
    step();
    // SRAM read is stale (zeros); bypass must supply 0x11.
    set_req(L2REQ_STORE, 26'h0005, 512'h2200, 64'h2, 1'b0, 2'd2, 2'd0, 1'b1,
            '0, '0, 1'b0);
    total++;
    if (wr_update_data !== 512'h2211 || wr_update_enable !== 1'b1) begin
      bad++;
      $display("FAIL b2b_second: data=%h en=%b want 2211/1", wr_update_data, wr_update_enable);
    end
    step();
    // Load to the same index right after: sees the accumulated line.
    set_req(L2REQ_LOAD, 26'h0005, '0, '0, 1'b0, 2'd2, 2'd0, 1'b1,
            '0, '0, 1'b0);
    total++;
    if (wr_update_enable !== 1'b0) begin
      bad++;
      $display("FAIL b2b_load_wen: got %b want 0", wr_update_enable);
    end
    step();
    total++;
    if (wr_data !== 512'h2211) begin
      bad++;
      $display("FAIL b2b_load_data: got %h want 2211", wr_data);
    end
    set_idle();
    step();
  endtask

  task automatic test_fill_load();
    logic [LINE_W-1:0] fd;
    fd = {64{8'h5A}};
    set_req(L2REQ_LOAD, 26'h0009, '0, '0, 1'b1, 2'd0, 2'd1, 1'b0,
            {64{8'hFF}}, fd, 1'b0);
    total++;
    if (wr_update_enable !== 1'b1 || wr_cache_write_index !== 8'h49 ||
        wr_update_data !== fd) begin
      bad++;
      $display("FAIL fill_write: en=%b idx=%h data=%h", wr_update_enable,
               wr_cache_write_index, wr_update_data);
    end
    step();
    total++;
    if (wr_is_l2_fill !== 1'b1 || wr_data !== fd) begin
      bad++;
      $display("FAIL fill_reg: fill=%b data=%h want 1/5a..", wr_is_l2_fill, wr_data);
    end
    set_idle();
    step();
  endtask

  task automatic test_store_sync();
    logic [LINE_W-1:0] p, d, m;
    p = {64{8'hC3}};
    d = {64{8'hEE}};
    m = {{60{8'hC3}}, {4{8'hEE}}};
    set_req(L2REQ_STORE_SYNC, 26'h0007, d, 64'hF, 1'b0, 2'd3, 2'd0, 1'b1,
            p, '0, 1'b0);
    total++;
    if (wr_update_enable !== 1'b0) begin
      bad++;
      $display("FAIL sync_fail_wen: got %b want 0", wr_update_enable);
    end
    step();
    total++;
    if (wr_store_sync_success !== 1'b0 || wr_data !== p) begin
      bad++;
      $display("FAIL sync_fail_reg: ok=%b data=%h want 0/c3..", wr_store_sync_success, wr_data);
    end
    set_req(L2REQ_STORE_SYNC, 26'h0007, d, 64'hF, 1'b0, 2'd3, 2'd0, 1'b1,
            p, '0, 1'b1);
    total++;
    if (wr_update_enable !== 1'b1 || wr_update_data !== m || wr_cache_write_index !== 8'hC7) begin
      bad++;
      $display("FAIL sync_ok_write: en=%b idx=%h data=%h", wr_update_enable,
               wr_cache_write_index, wr_update_data);
    end
    step();
    total++;
    if (wr_store_sync_success !== 1'b1 || wr_data !== m) begin
      bad++;
      $display("FAIL sync_ok_reg: ok=%b data=%h", wr_store_sync_success, wr_data);
    end
  endtask

  // Directly follows the successful sync store at index C7; load hits index 07.
  task automatic test_load_diff_index();
    logic [LINE_W-1:0] q;
    q = {64{8'h3C}};
    set_req(L2REQ_LOAD, 26'h0007, '0, '0, 1'b0, 2'd0, 2'd0, 1'b1,
            q, '0, 1'b0);
    total++;
    if (wr_update_enable !== 1'b0) begin
      bad++;
      $display("FAIL load_diff_wen: got %b want 0", wr_update_enable);
    end
    step();
    total++;
    if (wr_data !== q) begin
      bad++;
      $display("FAIL load_diff_data: got %h want 3c..", wr_data);
    end
    set_idle();
    step();
  endtask

  // Fill right after a store to the same index: bypass beats memory data.
  task automatic test_fill_bypass();
    set_req(L2REQ_STORE, 26'h0012, 512'h77, 64'h1, 1'b0, 2'd1, 2'd0, 1'b1,
            '0, '0, 1'b0);
    step();
    set_req(L2REQ_LOAD, 26'h0012, '0, '0, 1'b1, 2'd0, 2'd1, 1'b0,
            '0, {64{8'h5A}}, 1'b0);
    total++;
    if (wr_update_enable !== 1'b1 || wr_cache_write_index !== 8'h52 ||
        wr_update_data !== 512'h77) begin
      bad++;
      $display("FAIL fill_bypass: en=%b idx=%h data=%h want 1/52/77", wr_update_enable,
               wr_cache_write_index, wr_update_data);
    end
    set_idle();
    step();
  endtask

  task automatic test_reset_inflight();
    set_req(L2REQ_STORE, 26'h0003, 512'h99, 64'h1, 1'b0, 2'd0, 2'd0, 1'b1,
            '0, '0, 1'b0);
    step();
    set_req(L2REQ_STORE, 26'h0003, 512'h9900, 64'h2, 1'b0, 2'd0, 2'd0, 1'b1,
            '0, '0, 1'b0);
    #1;
    reset = 1'b1;
    rd_l2req_packet.valid = 1'b0;
    #1;
    total++;
    if (wr_data !== '0 || wr_l2req_packet.valid !== 1'b0 || wr_cache_hit !== 1'b0 ||
        dut.bypass_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_inflight_clear: data=%h vld=%b hit=%b byp=%b",
               wr_data, wr_l2req_packet.valid, wr_cache_hit, dut.bypass_valid);
    end
    total++;
    if (wr_update_enable !== 1'b0) begin
      bad++;
      $display("FAIL reset_inflight_wen: got %b want 0", wr_update_enable);
    end
    step();
    total++;
    if (dut.bypass_valid !== 1'b0 || wr_data !== '0) begin
      bad++;
      $display("FAIL reset_inflight_edge: byp=%b data=%h", dut.bypass_valid, wr_data);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_store_hit();
    test_back_to_back();
    test_fill_load();
    test_store_sync();
    test_load_diff_index();
    test_fill_bypass();
    test_reset_inflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
